ram_ctrl: RTL and testbench
===========================

Name: ram_ctrl

Overview:
Request/response controller directly upstream of the 32x8 ram. Converts valid/ready read, write and fill commands into the ram's clock/WE/address/Input signalling, and returns read data from the ram's Output with a held response handshake. It is the single master of the ram and replaces direct bench or processor driving of WE/address/Input. Fill mode writes an incrementing pattern over an address range, one word per cycle.

Parameters:
ADDR_W, 5, ram address width; the ram has 2**ADDR_W words.
DATA_W, 8, ram data width.
READ_LAT, 1, cycles from ram_address valid (WE=0) to ram_output valid; legal range 0..3.

Ports:
clock  input  1  single rising-edge clock, shared with the ram
reset  input  1  synchronous, active-low reset
req_valid  input  1  command present
req_ready  output  1  controller accepts a command this cycle
req_op  input  2  00=read, 01=write, 10=fill, 11=reserved
req_addr  input  ADDR_W  target or start address
req_len  input  ADDR_W  fill word count minus 1 (1..32 words)
req_data  input  DATA_W  write data, or first fill value
rsp_valid  output  1  read data available
rsp_data  output  DATA_W  read data
rsp_ready  input  1  consumer takes rsp_data
busy  output  1  high in any state other than IDLE
ram_we  output  1  to ram WE
ram_address  output  ADDR_W  to ram address
ram_input  output  DATA_W  to ram Input
ram_output  input  DATA_W  from ram Output

Behaviour:
- All outputs are registered. Reset (reset=0 sampled at a rising edge): state=IDLE; req_ready, rsp_valid, busy, ram_we = 0; rsp_data, ram_address, ram_input = 0. req_ready rises on the first edge with reset=1.
- Accept: handshake when req_valid && req_ready at a rising edge. req_ready=1 only in IDLE with rsp_valid=0. Command fields are captured at acceptance; later changes are ignored.
- States: IDLE, WRITE, READ_WAIT, RESP, FILL.
- WRITE: on the cycle after acceptance, ram_we=1, ram_address=addr, ram_input=data for exactly one cycle. Return to IDLE; req_ready=1 the following cycle. Throughput is 1 write per 2 cycles.
- READ: on the cycle after acceptance, ram_we=0 and ram_address=addr.
  - Remain in READ_WAIT for READ_LAT cycles, then capture ram_output into rsp_data and set rsp_valid=1 (state RESP).
  - rsp_data and rsp_valid hold until rsp_ready=1 at an edge, then rsp_valid=0 and state returns to IDLE.
  - With READ_LAT=0, capture occurs at the end of the address cycle.
- FILL: for k = 0..req_len, the ram receives one write per consecutive cycle with ram_we=1, ram_address=(addr+k) mod 32 and ram_input=(data+k) mod 256.
  - Address wraps 31->0.
  - ram_we drops the cycle after the last word; return to IDLE.
  - req_len=31 covers the whole ram.
- Reserved op 11: accepted, no ram access, return to IDLE next cycle.
- ram_we=0 in every state except WRITE and FILL write cycles.
- Reset mid-operation: the FSM aborts immediately and any pending response is dropped. A fill is truncated; words already written stay written, and no further writes occur after the reset edge.
- rsp_ready while rsp_valid=0: ignored.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_valid=1 -> all outputs 0, no ram write; req_ready=1 on the first cycle after reset=1.
- Write then read: write addr=5, data=8'h3C; read addr=5 -> ram_we pulses for exactly 1 cycle; rsp_valid after 1+READ_LAT cycles with rsp_data=8'h3C.
- Full fill: fill addr=0, len=31, data=1, then read all 32 addresses -> location j returns j+1; exactly 32 consecutive ram_we cycles are seen.
- Wrap fill: fill addr=30, len=3, data=8'hFE -> addr 30=FE, 31=FF, 0=00, 1=01; addr 2 unchanged.
- Response backpressure: read addr=7 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable; req_ready=0 throughout; one cycle after rsp_ready=1, rsp_valid=0 and req_ready=1.
- Reset mid-fill: fill addr=0, len=31, data=4, reset=0 after the 10th write -> addresses 0..9 hold 4..13, addresses 10..31 hold their prior contents, outputs return to reset values.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: the only master of the 32x8 ram. It turns valid/ready
// read, write and fill commands into WE/address/Input signalling and
// returns read data with a response that is held until it is taken.
//
// Ports:
//   clock, reset         rising-edge clock shared with the ram; sync active-low reset
//   req_valid/req_ready  command handshake
//   req_op               00 read, 01 write, 10 fill, 11 reserved (no ram access)
//   req_addr             target / start address
//   req_len              fill word count minus 1
//   req_data             write data / first fill value
//   rsp_valid/rsp_ready  read response handshake
//   rsp_data             read data
//   busy                 high whenever the FSM is not idle
//   ram_we, ram_address, ram_input   registered drive to the ram
//   ram_output           ram read data, valid READ_LAT cycles after the address
module ram_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_input,
  input  logic [DATA_W-1:0] ram_output
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_WAIT,
    S_RESP,
    S_FILL
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAT = ADDR_W'(READ_LAT);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_busy;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic                w_accept;

  assign w_accept = req_valid && r_req_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            // Command fields go straight into the ram drive registers, so
            // later changes on req_* have no effect.
            case (req_op)
              2'b00: begin
                r_we    <= 1'b0;
                r_addr  <= req_addr;
                r_cnt   <= CNT_LAT;
                r_state <= S_READ_WAIT;
              end
              2'b01: begin
                r_we    <= 1'b1;
                r_addr  <= req_addr;
                r_din   <= req_data;
                r_state <= S_WRITE;
              end
              2'b10: begin
                r_we    <= 1'b1;
                r_addr  <= req_addr;
                r_din   <= req_data;
                r_cnt   <= req_len;
                r_state <= S_FILL;
              end
              // Reserved op reuses the one-cycle WRITE turnaround with
              // ram_we left low, so it costs a cycle but touches nothing.
              default: begin
                r_we    <= 1'b0;
                r_state <= S_WRITE;
              end
            endcase
          end
        end

        S_WRITE: begin
          r_we        <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end

        S_READ_WAIT: begin
          // r_cnt counts the remaining ram latency; at zero ram_output
          // already reflects the address presented since acceptance.
          if (r_cnt == '0) begin
            r_rsp_data  <= ram_output;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - ADDR_W'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        S_FILL: begin
          // r_cnt holds the words still to write after the current one.
          if (r_cnt == '0) begin
            r_we        <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            r_din  <= r_din + DATA_W'(1);
            r_cnt  <= r_cnt - ADDR_W'(1);
          end
        end

        default: begin
          r_we        <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign busy        = r_busy;
  assign ram_we      = r_we;
  assign ram_address = r_addr;
  assign ram_input   = r_din;

endmodule

// File: tb/tb_ram_ctrl.sv
module tb_ram_ctrl;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned RL = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_len;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready;
  logic          busy;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_input;
  logic [DW-1:0] ram_output;

  always #5 clock = ~clock;

  ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .ram_we(ram_we), .ram_address(ram_address),
    .ram_input(ram_input), .ram_output(ram_output)
  );

  // 32x8 ram model, one cycle read latency
  logic [DW-1:0] mem [32];
  int wr_count = 0;
  always @(posedge clock) begin
    if (ram_we === 1'b1) begin
      mem[ram_address] <= ram_input;
      wr_count <= wr_count + 1;
    end
    ram_output <= mem[ram_address];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [AW-1:0] len, input logic [DW-1:0] d);
    int n = 0;
    req_op = op; req_addr = a; req_len = len; req_data = d; req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr  = a ^ 5'h1F;
    req_data  = ~d;
    req_len   = len ^ 5'h1F;
    req_op    = 2'b11;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                    input bit chk_lat);
    int lat = 0;
    issue(2'b00, a, '0, '0);
    @(negedge clock);
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 20) check({tag, "_timeout"}, 0, 1);
    if (chk_lat) check({tag, "_lat"}, lat, 1 + RL);
    check(tag, rsp_data, exp);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    if (chk_lat) begin
      check({tag, "_rsp_drop"}, rsp_valid, 0);
      check({tag, "_rdy_back"}, req_ready, 1);
    end
  endtask

  // Counts consecutive ram_we cycles starting at the negedge after acceptance.
  task automatic count_we(output int n, output logic [AW-1:0] last_a, output logic [DW-1:0] last_d);
    n = 0; last_a = '0; last_d = '0;
    @(negedge clock);
    while (ram_we === 1'b1 && n < 40) begin
      last_a = ram_address;
      last_d = ram_input;
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    int w0;
    int n;
    int k;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic [DW-1:0] e;

    reset = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 5'd5; req_len = '0; req_data = 8'h55;

    // reset with a pending command
    repeat (3) begin
      @(negedge clock);
      check("rst_outputs", {req_ready, rsp_valid, busy, ram_we, rsp_data, ram_address, ram_input}, 0);
    end
    check("rst_no_write", wr_count, 0);
    reset = 1'b1;
    @(negedge clock);
    check("rdy_after_rst", req_ready, 1);
    check("busy_after_rst", busy, 0);
    req_valid = 1'b0;
    @(negedge clock);

    // single write
    w0 = wr_count;
    issue(2'b01, 5'd5, '0, 8'h3C);
    @(negedge clock);
    check("wr_we", ram_we, 1);
    check("wr_addr", ram_address, 5);
    check("wr_data", ram_input, 8'h3C);
    check("wr_rdy_low", req_ready, 0);
    check("wr_busy", busy, 1);
    @(negedge clock);
    check("wr_we_drop", ram_we, 0);
    check("wr_rdy_back", req_ready, 1);
    check("wr_count", wr_count - w0, 1);

    rd("rd5", 5'd5, 8'h3C, 1'b1);

    // reserved op
    w0 = wr_count;
    issue(2'b11, 5'd2, '0, 8'h99);
    @(negedge clock);
    check("rsv_rdy_low", req_ready, 0);
    check("rsv_busy", busy, 1);
    check("rsv_we", ram_we, 0);
    @(negedge clock);
    check("rsv_rdy_back", req_ready, 1);
    check("rsv_no_write", wr_count - w0, 0);

    // full fill
    w0 = wr_count;
    issue(2'b10, 5'd0, 5'd31, 8'h01);
    count_we(n, la, ld);
    check("ffill_run", n, 32);
    check("ffill_count", wr_count - w0, 32);
    check("ffill_last_addr", la, 31);
    check("ffill_last_data", ld, 8'h20);
    check("ffill_rdy_back", req_ready, 1);
    for (int unsigned j = 0; j < 32; j++) begin
      e = 8'(j + 1);
      rd($sformatf("ffill_rd%0d", j), 5'(j), e, 1'b0);
    end

    // wrapping fill
    w0 = wr_count;
    issue(2'b10, 5'd30, 5'd3, 8'hFE);
    count_we(n, la, ld);
    check("wfill_run", n, 4);
    check("wfill_last_addr", la, 1);
    check("wfill_last_data", ld, 8'h01);
    rd("wfill_rd30", 5'd30, 8'hFE, 1'b0);
    rd("wfill_rd31", 5'd31, 8'hFF, 1'b0);
    rd("wfill_rd0",  5'd0,  8'h00, 1'b0);
    rd("wfill_rd1",  5'd1,  8'h01, 1'b0);
    rd("wfill_rd2",  5'd2,  8'h03, 1'b0);

    // response backpressure
    issue(2'b00, 5'd7, '0, '0);
    k = 0;
    @(negedge clock);
    while (rsp_valid !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (k >= 20) check("bp_timeout", 0, 1);
    for (int unsigned i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 8'h08);
      check("bp_rdy_low", req_ready, 0);
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("bp_valid_drop", rsp_valid, 0);
    check("bp_rdy_back", req_ready, 1);

    // reset during a fill, asserted during the 10th write cycle
    w0 = wr_count;
    issue(2'b10, 5'd0, 5'd31, 8'h04);
    k = 0;
    @(negedge clock);
    while (!(ram_we === 1'b1 && ram_address === 5'd9) && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (k >= 40) check("mid_timeout", 0, 1);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_outputs", {req_ready, rsp_valid, busy, ram_we, rsp_data, ram_address, ram_input}, 0);
    check("mid_wr_count", wr_count - w0, 10);
    repeat (3) @(negedge clock);
    check("mid_no_more_wr", wr_count - w0, 10);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rdy_back", req_ready, 1);
    for (int unsigned j = 0; j < 32; j++) begin
      if (j < 10)       e = 8'(j + 4);
      else if (j < 30)  e = 8'(j + 1);
      else if (j == 30) e = 8'hFE;
      else              e = 8'hFF;
      rd($sformatf("mid_rd%0d", j), 5'(j), e, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
